// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Brief    : Shared constants, register map, FSM encoding and address packing
//            for the rectangle-fill engine.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hC0;
    localparam logic [7:0] H_PIXELS          = 8'd160;
    localparam logic [7:0] V_PIXELS          = 8'd120;

    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_X1     = 3'd2;
    localparam logic [2:0] REG_Y1     = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam int CTRL_COLOUR = 0;
    localparam int CTRL_ABORT  = 6;
    localparam int CTRL_START  = 7;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERROR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

    function automatic logic [14:0] fb_addr_pack(input logic [7:0] x, input logic [6:0] y);
        return {y, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fill_engine_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_fill_engine_if
// Brief     : Bus control, CPU pixel path and frame-buffer port A signals.
// Revision  : 1.0 - initial release
// ============================================================================
interface vga_fill_engine_if;

    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic        CPU_PIX_WE;
    logic [14:0] CPU_PIX_ADDR;
    logic        CPU_PIX_DATA;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic        FB_WE;
    logic        BUSY;
    logic        IRQ;

    modport master (
        output BUS_ADDR, BUS_WE, CPU_PIX_WE, CPU_PIX_ADDR, CPU_PIX_DATA,
        input  FB_ADDR, FB_DATA, FB_WE, BUSY, IRQ
    );

    modport slave (
        input  BUS_ADDR, BUS_WE, CPU_PIX_WE, CPU_PIX_ADDR, CPU_PIX_DATA,
        output FB_ADDR, FB_DATA, FB_WE, BUSY, IRQ
    );

endinterface
`default_nettype wire

// File: rtl/vga_fill_engine_regs.sv
`default_nettype none
// ============================================================================
// Module   : vga_fill_regs
// Brief    : Bus decode, coordinate/control register bank and registered
//            read-data path with its output enable.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fill_regs
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] bus_addr,
    input  logic       bus_we,
    input  logic [7:0] bus_wdata,
    input  logic       busy,
    input  logic       done,
    input  logic       error,
    output logic [7:0] x0,
    output logic [7:0] y0,
    output logic [7:0] x1,
    output logic [7:0] y1,
    output logic       colour_next,
    output logic       start_wr,
    output logic       abort_wr,
    output logic [7:0] rd_data,
    output logic       rd_oe
);

    logic [7:0] offset;
    logic [2:0] sel;
    logic       in_range;
    logic       wr_en;
    logic       unused_wdata;

    logic [7:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic       colour_q, colour_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_oe_q, rd_oe_d;

    // Offset form avoids overflow of BASE_ADDR+6 near the top of the map.
    assign offset   = bus_addr - BASE_ADDR;
    assign in_range = (bus_addr >= BASE_ADDR) && (offset < 8'd6);
    assign sel      = offset[2:0];
    assign wr_en    = in_range && bus_we;

    assign start_wr     = wr_en && (sel == REG_CTRL) && bus_wdata[CTRL_START];
    assign abort_wr     = wr_en && (sel == REG_CTRL) && bus_wdata[CTRL_ABORT];
    assign unused_wdata = ^bus_wdata[5:1];

    always_comb begin
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        colour_d  = colour_q;
        if (wr_en) begin
            case (sel)
                REG_X0:   x0_d     = bus_wdata;
                REG_Y0:   y0_d     = bus_wdata;
                REG_X1:   x1_d     = bus_wdata;
                REG_Y1:   y1_d     = bus_wdata;
                REG_CTRL: colour_d = bus_wdata[CTRL_COLOUR];
                default:  ;
            endcase
        end

        rd_oe_d   = in_range && !bus_we;
        rd_data_d = 8'h00;
        case (sel)
            REG_X0:   rd_data_d = x0_q;
            REG_Y0:   rd_data_d = y0_q;
            REG_X1:   rd_data_d = x1_q;
            REG_Y1:   rd_data_d = y1_q;
            REG_CTRL: rd_data_d[CTRL_COLOUR] = colour_q;
            REG_STATUS: begin
                rd_data_d[STAT_BUSY]  = busy;
                rd_data_d[STAT_DONE]  = done;
                rd_data_d[STAT_ERROR] = error;
            end
            default:  rd_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x0_q      <= 8'h00;
            y0_q      <= 8'h00;
            x1_q      <= 8'h00;
            y1_q      <= 8'h00;
            colour_q  <= 1'b0;
            rd_data_q <= 8'h00;
            rd_oe_q   <= 1'b0;
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            colour_q  <= colour_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= rd_oe_d;
        end
    end

    assign x0          = x0_q;
    assign y0          = y0_q;
    assign x1          = x1_q;
    assign y1          = y1_q;
    assign colour_next = colour_d;
    assign rd_data     = rd_data_q;
    assign rd_oe       = rd_oe_q;

endmodule
`default_nettype wire

// File: rtl/vga_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_fill_engine
// Brief    : Rectangle-fill sequencer sharing frame-buffer port A with the
//            processor's direct pixel path (processor has priority).
// Revision : 1.0 - initial release
// ============================================================================
module vga_fill_engine
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [7:0]       BUS_DATA,
    vga_fill_engine_if.slave bus
);

    fill_state_e state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  wx0_q, wx0_d, wy0_q, wy0_d, wx1_q, wx1_d, wy1_q, wy1_d;
    logic        wcol_q, wcol_d;
    logic        done_q, done_d, error_q, error_d;
    logic [14:0] fb_addr_q, fb_addr_d;
    logic        fb_data_q, fb_data_d, fb_we_q, fb_we_d;

    logic [7:0]  reg_x0, reg_y0, reg_x1, reg_y1;
    logic        colour_next, start_wr, abort_wr, busy, rect_bad;
    logic [7:0]  rd_data;
    logic        rd_oe;

    vga_fill_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus_addr    (bus.BUS_ADDR),
        .bus_we      (bus.BUS_WE),
        .bus_wdata   (BUS_DATA),
        .busy        (busy),
        .done        (done_q),
        .error       (error_q),
        .x0          (reg_x0),
        .y0          (reg_y0),
        .x1          (reg_x1),
        .y1          (reg_y1),
        .colour_next (colour_next),
        .start_wr    (start_wr),
        .abort_wr    (abort_wr),
        .rd_data     (rd_data),
        .rd_oe       (rd_oe)
    );

    assign BUS_DATA = rd_oe ? rd_data : 8'bz;

    assign busy     = (state_q == ST_CHECK) || (state_q == ST_RUN);
    assign rect_bad = (wx0_q > wx1_q) || (wy0_q > wy1_q) ||
                      (wx1_q >= H_PIXELS) || (wy1_q >= V_PIXELS);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wx0_d     = wx0_q;
        wy0_d     = wy0_q;
        wx1_d     = wx1_q;
        wy1_d     = wy1_q;
        wcol_d    = wcol_q;
        done_d    = done_q;
        error_d   = error_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = 1'b0;

        if (bus.CPU_PIX_WE) begin
            fb_we_d   = 1'b1;
            fb_addr_d = bus.CPU_PIX_ADDR;
            fb_data_d = bus.CPU_PIX_DATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_wr) begin
                    state_d = ST_CHECK;
                    wx0_d   = reg_x0;
                    wy0_d   = reg_y0;
                    wx1_d   = reg_x1;
                    wy1_d   = reg_y1;
                    wcol_d  = colour_next;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (abort_wr) begin
                    state_d = ST_IDLE;
                end else if (rect_bad) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    x_d     = wx0_q;
                    y_d     = wy0_q;
                end
            end
            ST_RUN: begin
                // Abort also drops the pixel computed this cycle so FB_WE falls at once.
                if (abort_wr) begin
                    state_d = ST_IDLE;
                end else if (!bus.CPU_PIX_WE) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = fb_addr_pack(x_q, y_q[6:0]);
                    fb_data_d = wcol_q;
                    if (x_q == wx1_q) begin
                        x_d = wx0_q;
                        if (y_q == wy1_q) begin
                            state_d = ST_DONE;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            x_q       <= 8'h00;
            y_q       <= 8'h00;
            wx0_q     <= 8'h00;
            wy0_q     <= 8'h00;
            wx1_q     <= 8'h00;
            wy1_q     <= 8'h00;
            wcol_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            fb_addr_q <= 15'h0000;
            fb_data_q <= 1'b0;
            fb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wx0_q     <= wx0_d;
            wy0_q     <= wy0_d;
            wx1_q     <= wx1_d;
            wy1_q     <= wy1_d;
            wcol_q    <= wcol_d;
            done_q    <= done_d;
            error_q   <= error_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
        end
    end

    assign bus.FB_ADDR = fb_addr_q;
    assign bus.FB_DATA = fb_data_q;
    assign bus.FB_WE   = fb_we_q;
    assign bus.BUSY    = busy;
    assign bus.IRQ     = (state_q == ST_DONE);

endmodule
`default_nettype wire
